// File: rtl/fib_pkg.sv
// Shared state encodings, overflow-policy constants and helpers for the
// Fibonacci sequence engine.
package fib_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_LOAD = 2'b01;
   localparam logic [1:0] ST_RUN  = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_LOAD = ST_LOAD,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   localparam logic OVF_STOP = 1'b1;
   localparam logic OVF_WRAP = 1'b0;

   function automatic logic is_busy(state_t s);
      return (s == S_LOAD) || (s == S_RUN);
   endfunction

endpackage

// File: rtl/fib_seq_engine_if.sv
// Handshake and RAM write bus between the front end, the engine and the
// sequence RAM.
interface fib_seq_engine_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);

   logic              start;
   logic [ADDR_W:0]   n_terms;
   logic              stop_on_ovf;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              busy;
   logic              done;
   logic              ovf;
   logic [ADDR_W:0]   count;

   modport master (
      input  start, n_terms, stop_on_ovf,
      output mem_we, mem_addr, mem_wdata, busy, done, ovf, count
   );

   modport slave (
      output start, n_terms, stop_on_ovf,
      input  mem_we, mem_addr, mem_wdata, busy, done, ovf, count
   );

endinterface

// File: rtl/fib_datapath.sv
// Term pair registers and adder; a_bad marks a term that no longer fits in
// DATA_W bits (its true value is at least 2^DATA_W).
module fib_datapath #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   output logic [DATA_W-1:0] a,
   output logic              a_bad
);

   logic [DATA_W-1:0] a_q, b_q;
   logic              a_bad_q, b_bad_q;
   logic [DATA_W:0]   sum;

   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         a_bad_q <= 1'b0;
         b_bad_q <= 1'b0;
      end else if (load) begin
         a_q     <= '0;
         b_q     <= {{(DATA_W-1){1'b0}}, 1'b1};
         a_bad_q <= 1'b0;
         b_bad_q <= 1'b0;
      end else if (step) begin
         a_q     <= b_q;
         a_bad_q <= b_bad_q;
         b_q     <= sum[DATA_W-1:0];
         // Once any operand is out of range every later term is too.
         b_bad_q <= b_bad_q | a_bad_q | sum[DATA_W];
      end
   end

   assign a     = a_q;
   assign a_bad = a_bad_q;

endmodule

// File: rtl/fib_seq_engine.sv
// Fibonacci sequence generator: writes F(0)..F(N-1) into RAM, one term per
// cycle, with start/busy/done handshake and overflow policy.
//
// state | meaning
// IDLE  | waiting for start; count/ovf hold results of last run
// LOAD  | seed datapath with a=0, b=1
// RUN   | write one term per cycle
// DONE  | one-cycle completion pulse
import fib_pkg::*;

module fib_seq_engine #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input logic              clk,
   input logic              rst,
   fib_seq_engine_if.master bus
);

   localparam logic [ADDR_W:0] MAX_TERMS = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_q, state_d;
   logic [ADDR_W:0]   n_q, count_q, count_inc, n_clamped;
   logic [ADDR_W-1:0] addr_q;
   logic              stop_q, ovf_q;
   logic [DATA_W-1:0] term;
   logic              term_bad;
   logic              load_en, step_en, ovf_stop_hit, last_term, accept;

   assign accept       = (state_q == S_IDLE) && bus.start;
   assign load_en      = (state_q == S_LOAD);
   assign ovf_stop_hit = (state_q == S_RUN) && (stop_q == OVF_STOP) && term_bad;
   assign step_en      = (state_q == S_RUN) && !ovf_stop_hit;
   assign count_inc    = count_q + (ADDR_W+1)'(1);
   assign last_term    = (count_inc == n_q);
   assign n_clamped    = (bus.n_terms > MAX_TERMS) ? MAX_TERMS : bus.n_terms;

   fib_datapath #(.DATA_W(DATA_W)) u_datapath (
      .clk   (clk),
      .rst   (rst),
      .load  (load_en),
      .step  (step_en),
      .a     (term),
      .a_bad (term_bad)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.start) state_d = (bus.n_terms == '0) ? S_DONE : S_LOAD;
         S_LOAD: state_d = S_RUN;
         S_RUN:  if (ovf_stop_hit || last_term) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q     <= '0;
         addr_q  <= '0;
         count_q <= '0;
         stop_q  <= OVF_STOP;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         n_q     <= n_clamped;
         stop_q  <= bus.stop_on_ovf;
         addr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (step_en) begin
         addr_q  <= addr_q + ADDR_W'(1);
         count_q <= count_inc;
         // A bad term only gets written in wrap mode.
         if (term_bad && (stop_q == OVF_WRAP)) ovf_q <= 1'b1;
      end else if (ovf_stop_hit) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.mem_we    = step_en;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = term;
   assign bus.busy      = is_busy(state_q);
   assign bus.done      = (state_q == S_DONE);
   assign bus.ovf       = ovf_q;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Randomised and directed bench for fib_seq_engine (16-bit and 8-bit
// instances) against a per-run schedule model built from Fibonacci arithmetic.
module tb_fib_seq_engine;

   logic       clk = 1'b0;
   logic       rst, start, stop_on_ovf;
   logic [4:0] n_terms;

   always #5 clk = ~clk;

   fib_seq_engine_if #(.DATA_W(16), .ADDR_W(4)) bus16 ();
   fib_seq_engine_if #(.DATA_W(8),  .ADDR_W(4)) bus8 ();

   assign bus16.start = start;
   assign bus16.n_terms = n_terms;
   assign bus16.stop_on_ovf = stop_on_ovf;
   assign bus8.start = start;
   assign bus8.n_terms = n_terms;
   assign bus8.stop_on_ovf = stop_on_ovf;

   fib_seq_engine #(.DATA_W(16), .ADDR_W(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.master));
   fib_seq_engine #(.DATA_W(8),  .ADDR_W(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8.master));

   typedef struct {
      bit we;
      int addr;
      int wdata;
      bit busy;
      bit done;
      int count;
      bit ovf;
   } exp_t;

   exp_t sched [3][24];
   int   len [3];
   int   pos [2];
   exp_t cur [2];
   bit   model_ok = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   mem16 [16];
   int   mem8 [16];

   function automatic exp_t mk(bit we, int addr, int wdata, bit busy, bit done, int count, bit ovf);
      exp_t e;
      e.we = we; e.addr = addr; e.wdata = wdata; e.busy = busy;
      e.done = done; e.count = count; e.ovf = ovf;
      return e;
   endfunction

   // Cycle-by-cycle expectations from the cycle after the accepting edge.
   task automatic build(int s, int w, int n_in, bit stop);
      int     n;
      int     l;
      longint fa, fb, t, lim;
      bit     seen;
      n = (n_in > 16) ? 16 : n_in;
      fa = 0; fb = 1; lim = 64'd1 << w; seen = 1'b0; l = 0;
      if (n == 0) begin
         sched[s][0] = mk(0, 0, 0, 0, 1, 0, 0);
         len[s] = 1;
         return;
      end
      sched[s][l] = mk(0, 0, 0, 1, 0, 0, 0); l = l + 1;
      for (int k = 0; k < n; k++) begin
         if (fa >= lim && stop) begin
            sched[s][l] = mk(0, 0, 0, 1, 0, k, 0); l = l + 1;
            sched[s][l] = mk(0, 0, 0, 0, 1, k, 1); l = l + 1;
            len[s] = l;
            return;
         end
         sched[s][l] = mk(1, k % 16, int'(fa % lim), 1, 0, k, seen); l = l + 1;
         if (fa >= lim) seen = 1'b1;
         t = fa + fb; fa = fb; fb = t;
      end
      sched[s][l] = mk(0, 0, 0, 0, 1, n, seen); l = l + 1;
      len[s] = l;
   endtask

   task automatic chk(string nm, longint act, longint exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp(int i, longint we, longint addr, longint wdata, longint busy,
                      longint done, longint count, longint ovf);
      chk($sformatf("inst%0d mem_we", i), we, longint'(cur[i].we));
      chk($sformatf("inst%0d busy", i), busy, longint'(cur[i].busy));
      chk($sformatf("inst%0d done", i), done, longint'(cur[i].done));
      chk($sformatf("inst%0d count", i), count, longint'(cur[i].count));
      chk($sformatf("inst%0d ovf", i), ovf, longint'(cur[i].ovf));
      if (cur[i].we) begin
         chk($sformatf("inst%0d mem_addr", i), addr, longint'(cur[i].addr));
         chk($sformatf("inst%0d mem_wdata", i), wdata, longint'(cur[i].wdata));
      end
   endtask

   // Model: advance one cycle on every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               len[i] = 0; pos[i] = 0;
               cur[i] = mk(0, 0, 0, 0, 0, 0, 0);
               model_ok = 1'b1;
            end else if (pos[i] < len[i]) begin
               cur[i] = sched[i][pos[i]];
               pos[i] = pos[i] + 1;
            end else if (!cur[i].busy && !cur[i].done && start) begin
               build(i, (i == 0) ? 16 : 8, int'(n_terms), stop_on_ovf);
               cur[i] = sched[i][0];
               pos[i] = 1;
            end else begin
               cur[i].we = 1'b0; cur[i].busy = 1'b0; cur[i].done = 1'b0;
            end
         end
      end
   end

   // Compare and capture RAM writes mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (bus16.mem_we === 1'b1) mem16[bus16.mem_addr] = int'(bus16.mem_wdata);
         if (bus8.mem_we === 1'b1) mem8[bus8.mem_addr] = int'(bus8.mem_wdata);
         if (model_ok) begin
            cmp(0, longint'(bus16.mem_we), longint'(bus16.mem_addr), longint'(bus16.mem_wdata),
                longint'(bus16.busy), longint'(bus16.done), longint'(bus16.count), longint'(bus16.ovf));
            cmp(1, longint'(bus8.mem_we), longint'(bus8.mem_addr), longint'(bus8.mem_wdata),
                longint'(bus8.busy), longint'(bus8.done), longint'(bus8.count), longint'(bus8.ovf));
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(int n, bit stop);
      n_terms = 5'(n);
      stop_on_ovf = stop;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(22);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; n_terms = '0; stop_on_ovf = 1'b1;
      for (int i = 0; i < 16; i++) begin mem16[i] = -1; mem8[i] = -1; end
      cyc(3);
      rst = 1'b0;

      // Pin the model with hand-computed values.
      build(2, 16, 10, 1);
      chk("model len n10", len[2], 12);
      chk("model term9", sched[2][10].wdata, 34);
      chk("model done n10", sched[2][11].done, 1);
      build(2, 8, 16, 1);
      chk("model len stop8", len[2], 17);
      chk("model term13", sched[2][14].wdata, 233);
      chk("model nowrite14", sched[2][15].we, 0);
      chk("model count stop8", sched[2][16].count, 14);
      chk("model ovf stop8", sched[2][16].ovf, 1);
      build(2, 8, 16, 0);
      chk("model term14 wrap", sched[2][15].wdata, 121);
      chk("model term15 wrap", sched[2][16].wdata, 98);
      chk("model count wrap", sched[2][17].count, 16);
      build(2, 8, 0, 1);
      chk("model len n0", len[2], 1);

      run(10, 1);
      chk("mem16 addr9", mem16[9], 34);
      chk("mem16 addr5", mem16[5], 5);
      chk("count16 n10", longint'(bus16.count), 10);

      mem8[14] = -1; mem8[15] = -1;
      run(16, 1);
      chk("mem8 addr13", mem8[13], 233);
      chk("mem8 addr14 unwritten", mem8[14], -1);
      chk("ovf8 stop", longint'(bus8.ovf), 1);
      chk("count8 stop", longint'(bus8.count), 14);

      run(16, 0);
      chk("mem8 addr14 wrap", mem8[14], 121);
      chk("mem8 addr15 wrap", mem8[15], 98);
      chk("count8 wrap", longint'(bus8.count), 16);

      run(0, 1);
      run(31, 0);
      run(31, 1);

      // Reset during the fifth RUN cycle.
      n_terms = 5'd16; stop_on_ovf = 1'b0; start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(5);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("rst mem_we", longint'(bus8.mem_we), 0);
      chk("rst busy", longint'(bus8.busy), 0);
      chk("rst count", longint'(bus8.count), 0);
      cyc(3);
      run(12, 1);

      // start pulses during LOAD, mid-RUN and DONE.
      n_terms = 5'd14; stop_on_ovf = 1'b0; start = 1'b1;
      cyc(1);
      for (int k = 0; k < 20; k++) begin
         start = (k == 0 || k == 5 || k == 15);
         cyc(1);
      end
      start = 1'b0;
      cyc(25);

      // start held high: back-to-back runs.
      n_terms = 5'd3; stop_on_ovf = 1'b1; start = 1'b1;
      cyc(20);
      start = 1'b0;
      cyc(10);

      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         start = ($urandom_range(0, 3) == 0);
         n_terms = 5'($urandom_range(0, 31));
         stop_on_ovf = 1'($urandom_range(0, 1));
         cyc(1);
      end
      rst = 1'b0; start = 1'b0;
      cyc(25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fib_seq_engine.md
# fib_seq_engine

- Parametrised Fibonacci sequence generator that writes the first N terms, F(0)=0, F(1)=1, …, into a word-addressed memory port, one term per cycle.
- Successor to the three-state WAIT/LOAD/FIB controller: it now contains its own datapath and address counter.
- Adds a programmable term count, a start/busy/done handshake, overflow detection with two policies, and a terms-written count.
- Sits between the button/debounce front end and the sequence RAM.

## Interface
- DATA_W, 16: term width in bits (≥ 4).
- ADDR_W, 4: memory address width; maximum of 2^ADDR_W terms.
- clk  in  1: single clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: level, sampled only in IDLE.
- n_terms  in  ADDR_W+1: number of terms requested; latched on an accepted start.
- stop_on_ovf  in  1: overflow policy, latched on an accepted start.
  - 1 = stop before writing the first invalid term.
  - 0 = wrap modulo 2^DATA_W and keep going.
- mem_we  out  1: write strobe to the RAM.
- mem_addr  out  ADDR_W: write address.
- mem_wdata  out  DATA_W: term value.
- busy  out  1: high in LOAD and RUN.
- done  out  1: one-cycle pulse in DONE.
- ovf  out  1: sticky overflow flag; cleared on the next accepted start.
- count  out  ADDR_W+1: terms written in the current or last run.

## Operation
- States: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11. Any illegal encoding goes to IDLE.
- IDLE
  - start=1 and n_terms≠0: latch N = min(n_terms, 2^ADDR_W); clear addr, count and ovf; go to LOAD.
  - start=1 and n_terms=0: go to DONE with no writes; count=0.
  - start=0: stay in IDLE.
- LOAD: one cycle, no write. Set a=0, b=1, a_bad=b_bad=0. Go to RUN.
- RUN: mem_we=1 every cycle; mem_addr=addr; mem_wdata=a. On each edge:
  - a←b, a_bad←b_bad.
  - b←(a+b) mod 2^DATA_W.
  - b_bad←b_bad | a_bad | carry(a+b).
  - addr++, count++.
- Normal exit from RUN: after the write where count+1==N, go to DONE.
- Overflow, stop mode: when a_bad=1 in RUN, mem_we=0 that cycle, no write, count does not increment, ovf←1, go to DONE.
- Overflow, wrap mode: the term with a_bad=1 is written truncated and ovf←1. Later terms equal F(k) mod 2^DATA_W.
- If N and the overflow point coincide, the run ends normally; ovf is set only if an invalid term was actually written.
- DONE: done=1 for one cycle, then go to IDLE. start is ignored in LOAD, RUN and DONE.
- Outputs are Moore, decoded from state and registers; there are no combinational paths from inputs to outputs.
- Reset (any state, including mid-RUN): after the rst edge, state=IDLE and addr=count=a=b=0. mem_we=0, busy=0, done=0, ovf=0. Writes in progress are abandoned with no completion pulse.

## Timing
- An accepted start at edge t0 produces:
  - LOAD in cycle t0+1;
  - first write (addr 0, data 0) in cycle t0+2;
  - write k in cycle t0+2+k;
  - done in cycle t0+2+N.
- busy is high in cycles t0+1 through t0+1+N.
- n_terms=0: done in cycle t0+1; busy never rises.
- Stop on overflow at term j: no write in cycle t0+2+j; done in cycle t0+3+j.
- Back-to-back runs: start held high restarts in the IDLE cycle after DONE, so there is a minimum 1-cycle idle gap.
- count and ovf are stable from the done cycle until the next accepted start.

## Structure
- Package fib_pkg holds:
  - the state localparams (2-bit encodings above);
  - the overflow-policy constants OVF_STOP=1'b1 and OVF_WRAP=1'b0.
- Sub-module fib_datapath (DATA_W) contains:
  - a, b, a_bad, b_bad registers;
  - the DATA_W+1-bit adder.
  - Inputs: load and step enables.
  - Outputs: a and a_bad.
- The top level holds the FSM, the address/count counter and the N latch.

## Test plan
- DATA_W=16, ADDR_W=4, n_terms=10, stop=1 → writes addr0..9 = 0,1,1,2,3,5,8,13,21,34; done at t0+12; count=10; ovf=0.
- DATA_W=8, n_terms=16, stop=1 → writes addr0..13 with the last value 233; no write at addr14; ovf=1; count=14; done at t0+17.
- DATA_W=8, n_terms=16, stop=0 → 16 writes; addr14=121 (377 mod 256); addr15=98 (610 mod 256); ovf=1; count=16.
- n_terms=0 → no mem_we; done at t0+1; count=0. n_terms=31 with ADDR_W=4 → clamped to 16 writes, addr wraps to 0 exactly at the end.
- rst asserted during the 5th RUN cycle → on the next cycle mem_we=0, busy=0, count=0; no done pulse; a new start runs normally from addr 0.
- start pulsed in LOAD, mid-RUN and in DONE → ignored, run unaffected. start held high → second run's LOAD begins 2 cycles after the first done.
